// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port arbiter: Wishbone classic slave,
// CPU read port, SRAM port and the contention counter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              wb_cyc_i;
    logic              wb_strobe_i;
    logic              wb_we_i;
    logic [31:0]       wb_addr_i;
    logic [31:0]       wb_data_i;
    logic [3:0]        wb_sel_i;
    logic              wb_ack_o;
    logic [31:0]       wb_data_o;

    logic              cpu_req_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic              cpu_ack_o;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              halt_i;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic [15:0]       contention_o;

    // Arbiter side of the bundle
    modport slave (
        input  wb_cyc_i, wb_strobe_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
        output wb_ack_o, wb_data_o,
        input  cpu_req_i, cpu_addr_i, halt_i,
        output cpu_ack_o, cpu_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output contention_o
    );

    // Requester / memory side of the bundle
    modport master (
        output wb_cyc_i, wb_strobe_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
        input  wb_ack_o, wb_data_o,
        output cpu_req_i, cpu_addr_i, halt_i,
        input  cpu_ack_o, cpu_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  contention_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous SRAM port between a Wishbone
// classic slave and a CPU read port. Every access is IDLE -> ACCESS -> RESP.
module mem_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic                wb_clock_i,
    input  logic                wb_reset_n_i,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_WB  = 1'b1
    } grant_t;

    state_t            state;
    grant_t            winner;
    grant_t            last_grant;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              wb_ack_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [15:0]       contention_q;

    logic              wb_req;
    logic              cpu_req;
    logic              pick_wb;
    logic [31:0]       wb_data_ext;
    logic              unused_bits;

    // Request decode and round-robin choice: on a tie the side not granted last wins
    always_comb begin
        wb_req  = bus.wb_cyc_i & bus.wb_strobe_i;
        cpu_req = bus.cpu_req_i & ~bus.halt_i;
        pick_wb = wb_req & (~cpu_req | (last_grant == GRANT_CPU));
    end

    // Access sequencer; all port controls are registered so the access is immune to input changes
    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state        <= IDLE;
            winner       <= GRANT_CPU;
            last_grant   <= GRANT_CPU;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wb_ack_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            wb_data_q    <= '0;
            cpu_rdata_q  <= '0;
            contention_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb_req && cpu_req && (contention_q != 16'hFFFF)) begin
                        contention_q <= contention_q + 16'd1;
                    end
                    if (wb_req || cpu_req) begin
                        state    <= ACCESS;
                        mem_en_q <= 1'b1;
                        if (pick_wb) begin
                            winner      <= GRANT_WB;
                            last_grant  <= GRANT_WB;
                            mem_we_q    <= bus.wb_we_i & bus.wb_sel_i[0];
                            mem_addr_q  <= bus.wb_addr_i[ADDR_W+1:2];
                            mem_wdata_q <= bus.wb_data_i[DATA_W-1:0];
                        end else begin
                            winner      <= GRANT_CPU;
                            last_grant  <= GRANT_CPU;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.cpu_addr_i;
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    mem_en_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                    wb_ack_q  <= (winner == GRANT_WB);
                    cpu_ack_q <= (winner == GRANT_CPU);
                end
                RESP: begin
                    state     <= IDLE;
                    wb_ack_q  <= 1'b0;
                    cpu_ack_q <= 1'b0;
                    if (winner == GRANT_WB) begin
                        wb_data_q <= bus.mem_rdata_i;
                    end else begin
                        cpu_rdata_q <= bus.mem_rdata_i;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    // Read data is passed straight through during the ack cycle, then held from the capture register
    always_comb begin
        wb_data_ext = '0;
        if (wb_ack_q) begin
            wb_data_ext[DATA_W-1:0] = bus.mem_rdata_i;
        end else begin
            wb_data_ext[DATA_W-1:0] = wb_data_q;
        end
    end

    assign bus.wb_ack_o     = wb_ack_q;
    assign bus.wb_data_o    = wb_data_ext;
    assign bus.cpu_ack_o    = cpu_ack_q;
    assign bus.cpu_rdata_o  = cpu_ack_q ? bus.mem_rdata_i : cpu_rdata_q;
    assign bus.mem_en_o     = mem_en_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
    assign bus.contention_o = contention_q;

    // Address, data and select bits outside the memory word are intentionally ignored
    assign unused_bits = ^{bus.wb_addr_i[31:ADDR_W+2], bus.wb_addr_i[1:0],
                           bus.wb_data_i[31:DATA_W], bus.wb_sel_i[3:1]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small SRAM model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] sram_q;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .wb_clock_i   (clk),
        .wb_reset_n_i (rst_n),
        .bus          (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous SRAM: read data returns the old content one cycle after enable
    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                sram[bus.mem_addr_o] <= bus.mem_wdata_o;
            end
            sram_q <= sram[bus.mem_addr_o];
        end
    end

    assign bus.mem_rdata_i = sram_q;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] sel, input logic creq,
                                 input logic [ADDR_W-1:0] caddr, input logic halt);
        bus.wb_cyc_i    = cyc;
        bus.wb_strobe_i = stb;
        bus.wb_we_i     = we;
        bus.wb_addr_i   = addr;
        bus.wb_data_i   = data;
        bus.wb_sel_i    = sel;
        bus.cpu_req_i   = creq;
        bus.cpu_addr_i  = caddr;
        bus.halt_i      = halt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 12'h000, 0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_mem_en", {31'b0, bus.mem_en_o}, 32'd0);
        checkOutput("rst_acks", {30'b0, bus.wb_ack_o, bus.cpu_ack_o}, 32'd0);
        checkOutput("rst_contention", {16'b0, bus.contention_o}, 32'd0);
        checkOutput("rst_wb_data", bus.wb_data_o, 32'd0);
        checkOutput("rst_cpu_rdata", {24'b0, bus.cpu_rdata_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_no_req_en", {30'b0, bus.mem_en_o, bus.mem_we_o}, 32'd0);

        // WB write 0x10 <- 0xA5, inputs scrambled once the access has started
        applyStimulus(1, 1, 1, 32'h10, 32'hA5, 4'h1, 0, 12'h000, 0);
        tick();
        checkOutput("wr_mem_en", {31'b0, bus.mem_en_o}, 32'd1);
        checkOutput("wr_mem_we", {31'b0, bus.mem_we_o}, 32'd1);
        checkOutput("wr_mem_addr", {20'b0, bus.mem_addr_o}, 32'h004);
        checkOutput("wr_mem_wdata", {24'b0, bus.mem_wdata_o}, 32'hA5);
        applyStimulus(0, 0, 1, 32'h20, 32'h11, 4'h1, 0, 12'h000, 0);
        tick();
        checkOutput("wr_ack", {30'b0, bus.wb_ack_o, bus.cpu_ack_o}, 32'd2);
        checkOutput("wr_en_dropped", {31'b0, bus.mem_en_o}, 32'd0);
        tick();
        checkOutput("wr_ack_single", {30'b0, bus.wb_ack_o, bus.cpu_ack_o}, 32'd0);

        // CPU read of word 0x004 returns the written byte
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 12'h004, 0);
        tick();
        checkOutput("rd_mem_en_we", {30'b0, bus.mem_en_o, bus.mem_we_o}, 32'd2);
        checkOutput("rd_mem_addr", {20'b0, bus.mem_addr_o}, 32'h004);
        tick();
        checkOutput("rd_ack", {30'b0, bus.wb_ack_o, bus.cpu_ack_o}, 32'd1);
        checkOutput("rd_data", {24'b0, bus.cpu_rdata_o}, 32'hA5);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 12'h000, 0);
        tick();
        checkOutput("rd_ack_single", {31'b0, bus.cpu_ack_o}, 32'd0);
        checkOutput("rd_data_hold", {24'b0, bus.cpu_rdata_o}, 32'hA5);

        // WB write with sel[0]=0 acts as a read and leaves memory intact
        applyStimulus(1, 1, 1, 32'h10, 32'h3C, 4'h0, 0, 12'h000, 0);
        tick();
        checkOutput("sel0_mem_en_we", {30'b0, bus.mem_en_o, bus.mem_we_o}, 32'd2);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 12'h000, 0);
        tick();
        checkOutput("sel0_ack", {31'b0, bus.wb_ack_o}, 32'd1);
        checkOutput("sel0_wb_data", bus.wb_data_o, 32'hA5);
        tick();
        checkOutput("sel0_wb_data_hold", bus.wb_data_o, 32'hA5);
        checkOutput("sel0_sram", {24'b0, sram[12'h004]}, 32'hA5);

        // Halted CPU request is never granted
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 12'h004, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("halt_no_access", {30'b0, bus.mem_en_o, bus.cpu_ack_o}, 32'd0);
        end
        // Release halt, then re-raise it mid-access: the access still completes
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 12'h004, 0);
        tick();
        checkOutput("unhalt_mem_en", {31'b0, bus.mem_en_o}, 32'd1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 12'h004, 1);
        tick();
        checkOutput("unhalt_ack", {31'b0, bus.cpu_ack_o}, 32'd1);
        checkOutput("unhalt_data", {24'b0, bus.cpu_rdata_o}, 32'hA5);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 12'h000, 0);
        tick();
        checkOutput("no_tie_contention", {16'b0, bus.contention_o}, 32'd0);

        // Both sides requesting from reset: WB first, then strict alternation
        rst_n = 1'b0;
        applyStimulus(1, 1, 0, 32'h10, 32'h0, 4'h1, 1, 12'h004, 0);
        tick();
        checkOutput("rst_with_req_en", {31'b0, bus.mem_en_o}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("rr_mem_en", {31'b0, bus.mem_en_o}, 32'd1);
            checkOutput("rr_contention", {16'b0, bus.contention_o}, i + 1);
            tick();
            checkOutput("rr_grant", {30'b0, bus.wb_ack_o, bus.cpu_ack_o}, (i % 2 == 0) ? 32'd2 : 32'd1);
            tick();
        end

        // Reset during ACCESS aborts the access at once
        tick();
        checkOutput("abort_pre_en", {31'b0, bus.mem_en_o}, 32'd1);
        checkOutput("abort_pre_contention", {16'b0, bus.contention_o}, 32'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_async_en", {31'b0, bus.mem_en_o}, 32'd0);
        checkOutput("abort_contention", {16'b0, bus.contention_o}, 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 12'h000, 0);
        tick();
        checkOutput("abort_no_ack", {30'b0, bus.wb_ack_o, bus.cpu_ack_o}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 12'h004, 0);
        tick();
        checkOutput("post_rst_en", {31'b0, bus.mem_en_o}, 32'd1);
        tick();
        checkOutput("post_rst_ack", {31'b0, bus.cpu_ack_o}, 32'd1);
        checkOutput("post_rst_data", {24'b0, bus.cpu_rdata_o}, 32'hA5);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 12'h000, 0);
        tick();
        checkOutput("post_rst_idle", {30'b0, bus.cpu_ack_o, bus.mem_en_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
